// File: rtl/sprite_draw_scheduler.sv
// sprite_draw_scheduler
// Shares the single VGA plot port between two 4x4 sprite requesters
// (0 = airplane, 1 = obstacle). For the granted requester it optionally
// erases the sprite at its previous position, draws it at the new position
// and then pulses that requester's ack.
// Optional feature macro: SPRITE_SCHED_ERASE_EN (erase pass plus per-requester
// old-position tracking). When undefined, every transaction is draw-only.
module sprite_draw_scheduler #(
   parameter logic [2:0] BG_COLOUR = 3'b000,
   parameter logic [7:0] X_MAX     = 8'd159,
   parameter logic [7:0] Y_MAX     = 8'd119
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       req0,
   input  logic       req1,
   input  logic [7:0] x0,
   input  logic [7:0] x1,
   input  logic [7:0] y0,
   input  logic [7:0] y1,
   input  logic [2:0] colour0,
   input  logic [2:0] colour1,
   output logic       ack0,
   output logic       ack1,
   output logic       busy,
   output logic [7:0] X,
   output logic [7:0] Y,
   output logic [2:0] colour_out,
   output logic       plot
);

`ifdef SPRITE_SCHED_ERASE_EN
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_ERASE = 3'd2,
      S_DRAW  = 3'd3,
      S_ACK   = 3'd4
   } state_t;
`else
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_DRAW  = 3'd3,
      S_ACK   = 3'd4
   } state_t;
`endif

   state_t     state_r;
   logic       win_r;        // requester currently being served
   logic       last_r;       // requester served by the most recent transaction
   logic       granted_r;    // at least one transaction completed since reset
   logic [7:0] nx_r;
   logic [7:0] ny_r;
   logic [2:0] ncol_r;
   logic [3:0] cnt_r;
   logic       ack0_r;
   logic       ack1_r;
   logic       busy_r;
   logic [7:0] hold_x_r;
   logic [7:0] hold_y_r;
   logic [2:0] hold_col_r;

`ifdef SPRITE_SCHED_ERASE_EN
   logic [7:0] ox_r;
   logic [7:0] oy_r;
   logic [7:0] old_x_r [2];
   logic [7:0] old_y_r [2];
   logic [1:0] old_valid_r;
`endif

   logic       pick_s;
   logic       scan_s;
   logic [7:0] base_x_s;
   logic [7:0] base_y_s;
   logic [2:0] pix_col_s;
   logic [8:0] sum_x_s;
   logic [8:0] sum_y_s;
   logic       on_screen_s;

   // Round-robin winner: a tie goes to the requester not served last,
   // except before the first completed transaction where requester 0 wins.
   always_comb begin
      pick_s = 1'b0;
      if (req0 && req1) begin
         if (granted_r) begin
            pick_s = ~last_r;
         end else begin
            pick_s = 1'b0;
         end
      end else if (req1) begin
         pick_s = 1'b1;
      end else begin
         pick_s = 1'b0;
      end
   end

   // Select scan origin and colour for the current pixel pass.
   always_comb begin
      base_x_s  = nx_r;
      base_y_s  = ny_r;
      pix_col_s = BG_COLOUR;
      scan_s    = 1'b0;
      case (state_r)
`ifdef SPRITE_SCHED_ERASE_EN
         S_ERASE: begin
            base_x_s  = ox_r;
            base_y_s  = oy_r;
            pix_col_s = BG_COLOUR;
            scan_s    = 1'b1;
         end
`endif
         S_DRAW: begin
            pix_col_s = ncol_r;
            scan_s    = 1'b1;
         end
         default: begin
            scan_s = 1'b0;
         end
      endcase
   end

   // 9-bit sums so that pixels past the right/bottom edge are detected, not wrapped.
   assign sum_x_s     = {1'b0, base_x_s} + {7'd0, cnt_r[1:0]};
   assign sum_y_s     = {1'b0, base_y_s} + {7'd0, cnt_r[3:2]};
   assign on_screen_s = (sum_x_s <= {1'b0, X_MAX}) && (sum_y_s <= {1'b0, Y_MAX});

   // Pixel outputs: live during a scan, otherwise the last scanned pixel is held.
   always_comb begin
      if (scan_s) begin
         X          = sum_x_s[7:0];
         Y          = sum_y_s[7:0];
         colour_out = pix_col_s;
         plot       = on_screen_s;
      end else begin
         X          = hold_x_r;
         Y          = hold_y_r;
         colour_out = hold_col_r;
         plot       = 1'b0;
      end
   end

   assign ack0 = ack0_r;
   assign ack1 = ack1_r;
   assign busy = busy_r;

   // Remember the most recently presented pixel so outputs hold between scans.
   always_ff @(posedge clock) begin
      if (reset) begin
         hold_x_r   <= 8'd0;
         hold_y_r   <= 8'd0;
         hold_col_r <= 3'd0;
      end else if (scan_s) begin
         hold_x_r   <= sum_x_s[7:0];
         hold_y_r   <= sum_y_s[7:0];
         hold_col_r <= pix_col_s;
      end else begin
         hold_x_r   <= hold_x_r;
         hold_y_r   <= hold_y_r;
         hold_col_r <= hold_col_r;
      end
   end

   // Transaction sequencer: arbitrate, latch, erase, draw, acknowledge.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r     <= S_IDLE;
         win_r       <= 1'b0;
         last_r      <= 1'b0;
         granted_r   <= 1'b0;
         nx_r        <= 8'd0;
         ny_r        <= 8'd0;
         ncol_r      <= 3'd0;
         cnt_r       <= 4'd0;
         ack0_r      <= 1'b0;
         ack1_r      <= 1'b0;
         busy_r      <= 1'b0;
`ifdef SPRITE_SCHED_ERASE_EN
         ox_r        <= 8'd0;
         oy_r        <= 8'd0;
         old_x_r[0]  <= 8'd0;
         old_x_r[1]  <= 8'd0;
         old_y_r[0]  <= 8'd0;
         old_y_r[1]  <= 8'd0;
         old_valid_r <= 2'b00;
`endif
      end else begin
         ack0_r <= 1'b0;
         ack1_r <= 1'b0;
         case (state_r)
            S_IDLE: begin
               if (req0 || req1) begin
                  win_r   <= pick_s;
                  busy_r  <= 1'b1;
                  state_r <= S_LOAD;
               end else begin
                  busy_r  <= 1'b0;
               end
            end
            S_LOAD: begin
               nx_r   <= win_r ? x1 : x0;
               ny_r   <= win_r ? y1 : y0;
               ncol_r <= win_r ? colour1 : colour0;
               cnt_r  <= 4'd0;
`ifdef SPRITE_SCHED_ERASE_EN
               ox_r   <= old_x_r[win_r];
               oy_r   <= old_y_r[win_r];
               if (old_valid_r[win_r]) begin
                  state_r <= S_ERASE;
               end else begin
                  state_r <= S_DRAW;
               end
`else
               state_r <= S_DRAW;
`endif
            end
`ifdef SPRITE_SCHED_ERASE_EN
            S_ERASE: begin
               if (cnt_r == 4'd15) begin
                  cnt_r   <= 4'd0;
                  state_r <= S_DRAW;
               end else begin
                  cnt_r   <= cnt_r + 4'd1;
               end
            end
`endif
            S_DRAW: begin
               if (cnt_r == 4'd15) begin
                  cnt_r   <= 4'd0;
                  ack0_r  <= ~win_r;
                  ack1_r  <= win_r;
                  state_r <= S_ACK;
               end else begin
                  cnt_r   <= cnt_r + 4'd1;
               end
            end
            S_ACK: begin
               last_r    <= win_r;
               granted_r <= 1'b1;
               busy_r    <= 1'b0;
`ifdef SPRITE_SCHED_ERASE_EN
               old_x_r[win_r]     <= nx_r;
               old_y_r[win_r]     <= ny_r;
               old_valid_r[win_r] <= 1'b1;
`endif
               state_r   <= S_IDLE;
            end
            default: begin
               busy_r  <= 1'b0;
               state_r <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sprite_draw_scheduler.sv
// Testbench for sprite_draw_scheduler: a transaction-level model predicts the
// per-cycle plot-port trace, a compare process checks it every cycle, and
// directed scenarios pin the model with hand-computed literal expectations.
// Follows the DUT build: SPRITE_SCHED_ERASE_EN selects the erase behaviour.
module tb_sprite_draw_scheduler;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       req0 = 1'b0;
   logic       req1 = 1'b0;
   logic [7:0] x0 = 8'd0;
   logic [7:0] x1 = 8'd0;
   logic [7:0] y0 = 8'd0;
   logic [7:0] y1 = 8'd0;
   logic [2:0] colour0 = 3'd0;
   logic [2:0] colour1 = 3'd0;
   logic       ack0;
   logic       ack1;
   logic       busy;
   logic [7:0] X;
   logic [7:0] Y;
   logic [2:0] colour_out;
   logic       plot;

`ifdef SPRITE_SCHED_ERASE_EN
   localparam bit ERASE_EN = 1'b1;
`else
   localparam bit ERASE_EN = 1'b0;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   sprite_draw_scheduler dut (
      .clock(clock), .reset(reset),
      .req0(req0), .req1(req1),
      .x0(x0), .x1(x1), .y0(y0), .y1(y1),
      .colour0(colour0), .colour1(colour1),
      .ack0(ack0), .ack1(ack1), .busy(busy),
      .X(X), .Y(Y), .colour_out(colour_out), .plot(plot)
   );

   always #5 clock = ~clock;

   // ---------------- transaction-level model ----------------
   typedef struct {
      bit plot;
      int x;
      int y;
      int col;
      bit busy;
      bit a0;
      bit a1;
   } exp_t;

   exp_t q[$];
   exp_t cur;
   bit   m_valid = 1'b0;
   bit   m_pending = 1'b0;
   bit   m_win = 1'b0;
   bit   m_last = 1'b0;
   bit   m_granted = 1'b0;
   int   m_ox[2];
   int   m_oy[2];
   bit   m_ov[2];
   int   hx = 0;
   int   hy = 0;
   int   hc = 0;

   function automatic exp_t mk(bit p, int x, int y, int c, bit b, bit a0, bit a1);
      exp_t e;
      e.plot = p; e.x = x; e.y = y; e.col = c; e.busy = b; e.a0 = a0; e.a1 = a1;
      return e;
   endfunction

   // A 4x4 sprite pass: 16 row-major pixels, off-screen ones not plotted.
   task automatic push_sprite(int bx, int by, int c);
      for (int k = 0; k < 16; k++) begin
         int sx = bx + (k % 4);
         int sy = by + (k / 4);
         bit on = (sx <= 159) && (sy <= 119);
         hx = sx % 256; hy = sy % 256; hc = c;
         q.push_back(mk(on, hx, hy, c, 1'b1, 1'b0, 1'b0));
      end
   endtask

   // Expand the granted transaction using the inputs present at the LOAD cycle.
   task automatic build_trace();
      int nx = m_win ? int'(x1) : int'(x0);
      int ny = m_win ? int'(y1) : int'(y0);
      int nc = m_win ? int'(colour1) : int'(colour0);
      if (ERASE_EN && m_ov[m_win]) push_sprite(m_ox[m_win], m_oy[m_win], 0);
      push_sprite(nx, ny, nc);
      q.push_back(mk(1'b0, hx, hy, hc, 1'b1, !m_win, m_win));
      q.push_back(mk(1'b0, hx, hy, hc, 1'b0, 1'b0, 1'b0));
      m_ox[m_win] = nx; m_oy[m_win] = ny; m_ov[m_win] = 1'b1;
      m_last = m_win; m_granted = 1'b1;
   endtask

   // Model: at every edge decide what the next cycle must look like.
   initial begin
      forever begin
         @(posedge clock);
         if (reset) begin
            q.delete();
            m_pending = 1'b0; m_last = 1'b0; m_granted = 1'b0;
            for (int i = 0; i < 2; i++) begin m_ox[i] = 0; m_oy[i] = 0; m_ov[i] = 1'b0; end
            hx = 0; hy = 0; hc = 0;
            cur = mk(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
            m_valid = 1'b1;
         end else begin
            if (m_pending) begin
               build_trace();
               m_pending = 1'b0;
            end
            if (q.size() > 0) begin
               cur = q.pop_front();
            end else if (req0 || req1) begin
               if (req0 && req1) m_win = m_granted ? !m_last : 1'b0;
               else m_win = req1;
               cur = mk(1'b0, hx, hy, hc, 1'b1, 1'b0, 1'b0);
               m_pending = 1'b1;
            end else begin
               cur = mk(1'b0, hx, hy, hc, 1'b0, 1'b0, 1'b0);
            end
         end
      end
   end

   // Compare: every cycle after the first reset, DUT outputs against the model.
   initial begin
      forever begin
         @(negedge clock);
         if (m_valid) begin
            n_tests++;
            if (plot !== cur.plot || int'(X) != cur.x || int'(Y) != cur.y ||
                int'(colour_out) != cur.col || busy !== cur.busy ||
                ack0 !== cur.a0 || ack1 !== cur.a1) begin
               n_fail++;
               $display("FAIL cycle_compare t=%0t got plot=%0d X=%0d Y=%0d col=%0d busy=%0d ack0=%0d ack1=%0d expected plot=%0d X=%0d Y=%0d col=%0d busy=%0d ack0=%0d ack1=%0d",
                        $time, plot, X, Y, colour_out, busy, ack0, ack1,
                        cur.plot, cur.x, cur.y, cur.col, cur.busy, cur.a0, cur.a1);
            end
         end
      end
   end

   // ---------------- directed scenarios ----------------
   task automatic check(string name, int act, int expv);
      n_tests++;
      if (act != expv) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, expv);
      end
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      @(negedge clock);
      while (busy && n < 100) begin
         @(negedge clock);
         n++;
      end
      check("wait_idle_timeout", int'(busy), 0);
   endtask

   // One request from an idle block; E0 is the first edge after req rises.
   task automatic run_single(input bit which, input logic [7:0] x, input logic [7:0] y,
                             input logic [2:0] col, output int plots, output int ack_c,
                             output int fx, output int fy, output int fc);
      bit done = 1'b0;
      wait_idle();
      if (which) begin x1 = x; y1 = y; colour1 = col; req1 = 1'b1; end
      else begin x0 = x; y0 = y; colour0 = col; req0 = 1'b1; end
      plots = 0; ack_c = -1; fx = -1; fy = -1; fc = -1;
      for (int c = 0; c < 100 && !done; c++) begin
         @(posedge clock);
         #1;
         if (plot) begin
            if (plots == 0) begin fx = int'(X); fy = int'(Y); fc = int'(colour_out); end
            plots++;
         end
         if (which ? ack1 : ack0) begin
            ack_c = c; done = 1'b1;
            req0 = 1'b0; req1 = 1'b0;
         end
      end
      if (!done) begin
         req0 = 1'b0; req1 = 1'b0;
         check("ack_timeout", 0, 1);
      end
   endtask

   int plots, ack_c, fx, fy, fc;
   int ord[3];
   int n_ack;
   int zero_ack0;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      check("reset_plot", int'(plot), 0);
      check("reset_busy", int'(busy), 0);
      check("reset_X", int'(X), 0);
      check("reset_ack", int'(ack0) + int'(ack1), 0);

      // Scenario 1: first draw, no erase possible.
      run_single(1'b0, 8'd10, 8'd60, 3'b111, plots, ack_c, fx, fy, fc);
      check("s1_plots", plots, 16);
      check("s1_ack_edge", ack_c, 17);
      check("s1_first_x", fx, 10);
      check("s1_first_y", fy, 60);
      check("s1_first_col", fc, 7);

      // Scenario 2: move down one row; erase pass when compiled in.
      run_single(1'b0, 8'd10, 8'd61, 3'b111, plots, ack_c, fx, fy, fc);
`ifdef SPRITE_SCHED_ERASE_EN
      check("s2_plots", plots, 32);
      check("s2_ack_edge", ack_c, 33);
      check("s2_first_y", fy, 60);
      check("s2_first_col", fc, 0);
`else
      check("s2_plots", plots, 16);
      check("s2_ack_edge", ack_c, 17);
      check("s2_first_y", fy, 61);
      check("s2_first_col", fc, 7);
`endif

      // Scenario 3: simultaneous requests after reset, then req0 re-raised.
      do_reset();
      wait_idle();
      x0 = 8'd20; y0 = 8'd30; colour0 = 3'd2;
      x1 = 8'd40; y1 = 8'd50; colour1 = 3'd4;
      req0 = 1'b1; req1 = 1'b1;
      n_ack = 0; zero_ack0 = 0;
      for (int c = 0; c < 300 && n_ack < 3; c++) begin
         @(posedge clock);
         #1;
         if (ack0) begin
            ord[n_ack] = 0; n_ack++;
            zero_ack0++;
            if (zero_ack0 == 2) req0 = 1'b0;
         end
         if (ack1) begin
            ord[n_ack] = 1; n_ack++;
            req1 = 1'b0;
         end
      end
      req0 = 1'b0; req1 = 1'b0;
      check("rr_count", n_ack, 3);
      check("rr_first", ord[0], 0);
      check("rr_second", ord[1], 1);
      check("rr_third", ord[2], 0);

      // Scenario 4: bottom-right corner clipping.
      do_reset();
      run_single(1'b1, 8'd158, 8'd118, 3'd5, plots, ack_c, fx, fy, fc);
      check("s4_plots", plots, 4);
      check("s4_ack_edge", ack_c, 17);
      check("s4_first_x", fx, 158);

      // Scenario 5: reset in the 5th scan cycle of a move.
      run_single(1'b0, 8'd30, 8'd40, 3'd1, plots, ack_c, fx, fy, fc);
      wait_idle();
      x0 = 8'd31; y0 = 8'd40; colour0 = 3'd1; req0 = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(posedge clock);
         #1;
      end
      check("s5_plot_before_reset", int'(plot), 1);
      reset = 1'b1;
      @(posedge clock);
      #1;
      check("s5_plot_after_reset", int'(plot), 0);
      check("s5_busy_after_reset", int'(busy), 0);
      check("s5_ack_after_reset", int'(ack0), 0);
      reset = 1'b0; req0 = 1'b0;
      run_single(1'b0, 8'd31, 8'd40, 3'd1, plots, ack_c, fx, fy, fc);
      check("s5_plots_after", plots, 16);
      check("s5_ack_edge_after", ack_c, 17);
      check("s5_first_x_after", fx, 31);

      repeat (3) @(negedge clock);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
